program_loader: RTL and testbench

Upstream feeder of `instruction_fetch`. Receives a program as a byte stream, typically from the debug UART receiver. Assembles the bytes into 32-bit big-endian words and writes them into instruction memory through the fetch stage's write port. Once the halt word has been stored, it asserts `mips_enable` so the pipeline can start executing.

---
 rtl/program_loader.sv | 180 ++++++++++++++++++
 tb/tb_program_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//   Receives a program as a byte stream (typically from the debug UART),
//   packs each group of four bytes into a big-endian 32-bit word and writes
//   it into instruction memory. Once the halt word has been stored, it
//   raises mips_enable so the pipeline can start.
//
// Parameters
//   MEM_DEPTH  instruction memory depth in words (power of two, >= 4)
//   HALT_WORD  end-of-program marker, written to memory like any other word
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   load_start                     start pulse (honoured in IDLE/DONE/ERROR)
//   rx_data, rx_valid, rx_ready    byte stream handshake
//   wr_memory_instruction_enable   one-cycle memory write strobe
//   instruction_to_write           word being written (registered)
//   address_to_write               byte address of that word (registered)
//   mips_enable, load_done         program loaded, pipeline may run
//   load_error                     memory filled without a halt word, or bad checksum
//   words_loaded                   words written in the current load
//
// Build option
//   LOADER_CHECKSUM_EN  adds a CHECK state: after the halt word, one more
//                       byte must equal the XOR of every program byte.

module program_loader #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_memory_instruction_enable,
    output logic [31:0] instruction_to_write,
    output logic [31:0] address_to_write,
    output logic        mips_enable,
    output logic        load_done,
    output logic        load_error,
    output logic [31:0] words_loaded
);

    localparam logic [31:0] LAST_ADDR = 32'((MEM_DEPTH - 1) * 4);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECEIVE = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_ERROR   = 3'd4,
        S_CHECK   = 3'd5
`else
        S_ERROR   = 3'd4
`endif
    } state_t;

    state_t      state, state_n;
    logic [1:0]  byte_cnt;
    logic [23:0] word_sr;     // first three bytes of the word in flight
    logic [31:0] addr;        // address the next completed word will use
    logic        start;
    logic        accept;
    logic        is_halt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept  = rx_valid && rx_ready;
    assign is_halt = (instruction_to_write == HALT_WORD);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_n                      = state;
        start                        = 1'b0;
        rx_ready                     = 1'b0;
        wr_memory_instruction_enable = 1'b0;
        mips_enable                  = 1'b0;
        load_done                    = 1'b0;
        load_error                   = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    start   = 1'b1;
                    state_n = S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                rx_ready = 1'b1;
                if (rx_valid && byte_cnt == 2'd3) state_n = S_WRITE;
            end
            S_WRITE: begin
                wr_memory_instruction_enable = 1'b1;
                if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
                    state_n = S_CHECK;
`else
                    state_n = S_DONE;
`endif
                end else if (addr == LAST_ADDR) begin
                    state_n = S_ERROR;
                end else begin
                    state_n = S_RECEIVE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                rx_ready = 1'b1;
                if (rx_valid) state_n = (rx_data == csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE: begin
                mips_enable = 1'b1;
                load_done   = 1'b1;
                if (load_start) begin
                    start   = 1'b1;
                    state_n = S_RECEIVE;
                end
            end
            S_ERROR: begin
                load_error = 1'b1;
                if (load_start) begin
                    start   = 1'b1;
                    state_n = S_RECEIVE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: byte assembly, write word/address, counters
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt             <= '0;
            word_sr              <= '0;
            addr                 <= '0;
            instruction_to_write <= '0;
            address_to_write     <= '0;
            words_loaded         <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum                 <= '0;
`endif
        end else begin
            if (start) begin
                byte_cnt     <= '0;
                addr         <= '0;
                words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum         <= '0;
`endif
            end
            if (state == S_RECEIVE && accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                word_sr  <= {word_sr[15:0], rx_data};
`ifdef LOADER_CHECKSUM_EN
                csum     <= csum ^ rx_data;
`endif
                // Output registers only change on word completion, so they
                // hold steady through WRITE and afterwards.
                if (byte_cnt == 2'd3) begin
                    instruction_to_write <= {word_sr, rx_data};
                    address_to_write     <= addr;
                end
            end
            if (state == S_WRITE) begin
                words_loaded <= words_loaded + 32'd1;
                if (!is_halt && addr != LAST_ADDR) addr <= addr + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        rdy0, wr0, mips0, done0, err0;
    logic [31:0] d0, a0, wl0;
    logic        rdy1, wr1, mips1, done1, err1;
    logic [31:0] d1, a1, wl1;

    int total = 0;
    int bad   = 0;
    int dbl   = 0;
    logic wr0_q = 1'b0, wr1_q = 1'b0;

    logic [63:0] got_q[2][$];
    logic [63:0] exp_q[2][$];

    always #5 clk = ~clk;

    program_loader #(.MEM_DEPTH(256)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy0),
        .wr_memory_instruction_enable(wr0), .instruction_to_write(d0),
        .address_to_write(a0), .mips_enable(mips0), .load_done(done0),
        .load_error(err0), .words_loaded(wl0)
    );

    program_loader #(.MEM_DEPTH(4)) dut_s (
        .clk(clk), .reset(reset), .load_start(load_start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy1),
        .wr_memory_instruction_enable(wr1), .instruction_to_write(d1),
        .address_to_write(a1), .mips_enable(mips1), .load_done(done1),
        .load_error(err1), .words_loaded(wl1)
    );

    // Write monitors; also flag any strobe longer than one cycle
    always @(negedge clk) begin
        if (wr0) begin
            got_q[0].push_back({a0, d0});
            if (wr0_q) dbl++;
        end
        if (wr1) begin
            got_q[1].push_back({a1, d1});
            if (wr1_q) dbl++;
        end
        wr0_q = wr0;
        wr1_q = wr1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: walk the byte list word by word using the loader's rules.
    // st: 0 still loading, 1 done, 2 error, 3 waiting for checksum byte
    task automatic model(input bq_t bs, input int depth, input int d,
                         output int st, output int nw);
        logic [31:0] w;
        logic [7:0]  x;
        int k, i;
        exp_q[d].delete();
        x = 0; k = 0; i = 0; st = 0; nw = 0;
        while (st == 0 && k + 4 <= bs.size()) begin
            w = {bs[k], bs[k+1], bs[k+2], bs[k+3]};
            x = x ^ bs[k] ^ bs[k+1] ^ bs[k+2] ^ bs[k+3];
            exp_q[d].push_back({32'(i) * 32'd4, w});
            nw++;
            k += 4;
            if (w == 32'hFFFF_FFFF) begin
`ifdef LOADER_CHECKSUM_EN
                if (k < bs.size()) st = (bs[k] == x) ? 1 : 2;
                else               st = 3;
`else
                st = 1;
`endif
            end else if (i == depth - 1) begin
                st = 2;
            end else begin
                i++;
            end
        end
    endtask

    function automatic logic [7:0] xor_of(input bq_t bs);
        logic [7:0] x = 0;
        foreach (bs[j]) x ^= bs[j];
        return x;
    endfunction

    task automatic do_start();
        @(negedge clk);
        got_q[0].delete();
        got_q[1].delete();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("start_rdy", rdy0, 1'b1);
        chk("start_mips", {mips0, mips1}, 2'b00);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rdy0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("rdy_timeout", 1'b1, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = $urandom();
    endtask

    task automatic send_stream(input bq_t bs);
        foreach (bs[j]) send_byte(bs[j]);
    endtask

    task automatic verify(input string tag, input bq_t bs);
        int st, nw;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            model(bs, (d == 0) ? 256 : 4, d, st, nw);
            chk({tag, "_nwr"}, got_q[d].size(), exp_q[d].size());
            for (int j = 0; j < got_q[d].size() && j < exp_q[d].size(); j++)
                chk({tag, "_wr"}, got_q[d][j], exp_q[d][j]);
            chk({tag, "_wl"}, (d == 0) ? wl0 : wl1, nw);
            chk({tag, "_st"}, (d == 0) ? {mips0, done0, err0} : {mips1, done1, err1},
                {st == 1, st == 1, st == 2});
        end
    endtask

    function automatic bq_t with_sum(input bq_t bs, input bit corrupt);
        bq_t r = bs;
`ifdef LOADER_CHECKSUM_EN
        r.push_back(xor_of(bs) ^ (corrupt ? 8'h01 : 8'h00));
`endif
        return r;
    endfunction

    initial begin
        bq_t s;
        reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_out0", {rdy0, wr0, d0, a0, mips0, done0, err0, wl0}, 128'd0);
        chk("rst_out1", {rdy1, wr1, d1, a1, mips1, done1, err1, wl1}, 128'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_rdy", rdy0, 1'b0);

        // Basic program, with halt timing
        do_start();
        s = with_sum('{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0);
        send_stream(s);
`ifndef LOADER_CHECKSUM_EN
        chk("halt_n1", {wr0, mips0}, 2'b10);
        @(negedge clk);
        chk("halt_n2", {wr0, mips0, done0}, 3'b011);
`endif
        verify("basic", s);

        // Byte ordering; also exercises reload from DONE
        do_start();
        s = with_sum('{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0);
        send_stream(s);
        verify("order", s);
        if (got_q[0].size() > 1) begin
            chk("order_w0", got_q[0][0], {32'd0, 32'h1234_5678});
            chk("order_a1", got_q[0][1][63:32], 32'd4);
        end

        // Randomized programs
        for (int t = 0; t < 8; t++) begin
            int n = $urandom_range(0, 3);
            s = {};
            for (int j = 0; j < 4 * n; j++) s.push_back(8'($urandom_range(0, 254)));
            repeat (4) s.push_back(8'hFF);
            s = with_sum(s, ($urandom_range(0, 3) == 0));
            do_start();
            send_stream(s);
            verify("rand", s);
        end

        // Fill the small memory with no halt word
        do_start();
        s = {};
        for (int j = 0; j < 16; j++) s.push_back(8'(j + 1));
        send_stream(s);
        verify("full", s);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            chk("full_rdy", rdy1, 1'b0);
        end
        rx_valid = 1'b0;
        chk("full_nowr", got_q[1].size(), 4);
        chk("full_err", {mips1, err1}, 2'b01);

        // Reset in the middle of a word
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_start();
        send_byte(8'hDE);
        send_byte(8'hAD);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst0", {rdy0, wr0, d0, a0, mips0, done0, err0, wl0}, 128'd0);
        chk("mid_rst1", {rdy1, wr1, d1, a1, mips1, done1, err1, wl1}, 128'd0);
        reset = 1'b0;
        do_start();
        s = with_sum('{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0);
        send_stream(s);
        verify("after_rst", s);

`ifdef LOADER_CHECKSUM_EN
        do_start();
        s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04};
        send_stream(s);
        verify("csum_ok", s);
        chk("csum_ok_done", {mips0, done0, err0}, 3'b110);
        do_start();
        s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h05};
        send_stream(s);
        verify("csum_bad", s);
        chk("csum_bad_err", {mips0, done0, err0}, 3'b001);
`endif

        chk("strobe_width", dbl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
